// File: rtl/fir_frame_sequencer.sv
// Frame controller for a FIR datapath: clear, stream a frame, optionally flush the tail, drain, done.
// Optional feature macro: FIR_SEQ_FLUSH_EN (zero-flush of NUM_TAPS-1 samples after each frame).

module fir_frame_sequencer #(
  parameter int IN_INTE_WL     = 4,
  parameter int IN_FRAC_WL     = 8,
  parameter int OUT_INTE_WL    = 4,
  parameter int OUT_FRAC_WL    = 8,
  parameter int NUM_TAPS       = 15,
  parameter int MAX_FRAME      = 1024,
  parameter int DRAIN_TIMEOUT  = 64,
  localparam int IN_WL         = IN_INTE_WL + IN_FRAC_WL,
  localparam int OUT_WL        = OUT_INTE_WL + OUT_FRAC_WL,
  localparam int FL_W          = $clog2(MAX_FRAME + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [FL_W-1:0]   frame_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  input  logic [IN_WL-1:0]  s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              fir_rst_o,
  output logic [IN_WL-1:0]  fir_data_in_o,
  output logic              fir_in_valid_o,
  input  logic [OUT_WL-1:0] fir_data_out_i,
  input  logic              fir_out_valid_i,
  output logic [OUT_WL-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o
);

  localparam int CNT_W = $clog2(MAX_FRAME + NUM_TAPS);
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
`ifdef FIR_SEQ_FLUSH_EN
  localparam int FLUSH_LEN = NUM_TAPS - 1;
  localparam int FLC_W     = (NUM_TAPS > 2) ? $clog2(NUM_TAPS - 1) : 1;
`else
  localparam int FLUSH_LEN = 0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
`ifdef FIR_SEQ_FLUSH_EN
  localparam logic [2:0] S_FLUSH  = 3'd3;
`endif
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [FL_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]  exp_q, exp_d;
  logic [FL_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              error_q, error_d;
`ifdef FIR_SEQ_FLUSH_EN
  logic [FLC_W-1:0]  fl_cnt_q, fl_cnt_d;
`endif

  logic              busy_q, done_q, s_ready_q, fir_rst_q;
  logic              fir_in_valid_q, fir_in_valid_d;
  logic [IN_WL-1:0]  fir_data_in_q, fir_data_in_d;
  logic              m_valid_q, m_last_q, m_last_d;
  logic [OUT_WL-1:0] m_data_q, m_data_d;

  logic              hs_s;
  logic              active_s;
  logic              out_acc_s;
  logic [FL_W-1:0]   len_clamp_s;

  assign hs_s        = (state_q == S_STREAM) && s_valid_i;
  assign len_clamp_s = (frame_len_i > FL_W'(MAX_FRAME)) ? FL_W'(MAX_FRAME) : frame_len_i;

  // Results are only counted while the frame owns the FIR and the expected count is not yet met.
  always_comb begin
    active_s = (state_q == S_STREAM) || (state_q == S_DRAIN);
`ifdef FIR_SEQ_FLUSH_EN
    active_s = active_s || (state_q == S_FLUSH);
`endif
    out_acc_s = fir_out_valid_i && active_s && (out_cnt_q != exp_q);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    exp_d          = exp_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_acc_s ? (out_cnt_q + CNT_W'(1)) : out_cnt_q;
    tmo_d          = tmo_q;
    error_d        = error_q;
`ifdef FIR_SEQ_FLUSH_EN
    fl_cnt_d       = fl_cnt_q;
`endif
    fir_in_valid_d = 1'b0;
    fir_data_in_d  = {IN_WL{1'b0}};
    m_data_d       = out_acc_s ? fir_data_out_i : m_data_q;
    m_last_d       = out_acc_s && ((out_cnt_q + CNT_W'(1)) == exp_q);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          error_d = 1'b0;
          len_d   = len_clamp_s;
          exp_d   = CNT_W'(len_clamp_s) + CNT_W'(FLUSH_LEN);
          if (frame_len_i == {FL_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        in_cnt_d  = {FL_W{1'b0}};
        out_cnt_d = {CNT_W{1'b0}};
        tmo_d     = {TMO_W{1'b0}};
        error_d   = 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
        fl_cnt_d  = {FLC_W{1'b0}};
`endif
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (hs_s) begin
          fir_in_valid_d = 1'b1;
          fir_data_in_d  = s_data_i;
          in_cnt_d       = in_cnt_q + FL_W'(1);
          if ((in_cnt_q + FL_W'(1)) == len_q) begin
`ifdef FIR_SEQ_FLUSH_EN
            state_d = S_FLUSH;
`else
            state_d = S_DRAIN;
`endif
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
`ifdef FIR_SEQ_FLUSH_EN
      S_FLUSH: begin
        fir_in_valid_d = 1'b1;
        if (fl_cnt_q == FLC_W'(NUM_TAPS - 2)) begin
          state_d = S_DRAIN;
        end else begin
          fl_cnt_d = fl_cnt_q + FLC_W'(1);
        end
      end
`endif
      S_DRAIN: begin
        // The count is checked registered so that done lands one cycle after m_last.
        if (out_cnt_q == exp_q) begin
          state_d = S_DONE;
        end else if (tmo_q == TMO_W'(DRAIN_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      len_q          <= {FL_W{1'b0}};
      exp_q          <= {CNT_W{1'b0}};
      in_cnt_q       <= {FL_W{1'b0}};
      out_cnt_q      <= {CNT_W{1'b0}};
      tmo_q          <= {TMO_W{1'b0}};
      error_q        <= 1'b0;
`ifdef FIR_SEQ_FLUSH_EN
      fl_cnt_q       <= {FLC_W{1'b0}};
`endif
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      s_ready_q      <= 1'b0;
      fir_rst_q      <= 1'b1;
      fir_in_valid_q <= 1'b0;
      fir_data_in_q  <= {IN_WL{1'b0}};
      m_valid_q      <= 1'b0;
      m_last_q       <= 1'b0;
      m_data_q       <= {OUT_WL{1'b0}};
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      exp_q          <= exp_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      tmo_q          <= tmo_d;
      error_q        <= error_d;
`ifdef FIR_SEQ_FLUSH_EN
      fl_cnt_q       <= fl_cnt_d;
`endif
      busy_q         <= (state_d != S_IDLE);
      done_q         <= (state_d == S_DONE);
      s_ready_q      <= (state_d == S_STREAM);
      fir_rst_q      <= (state_d == S_CLEAR);
      fir_in_valid_q <= fir_in_valid_d;
      fir_data_in_q  <= fir_data_in_d;
      m_valid_q      <= out_acc_s;
      m_last_q       <= m_last_d;
      m_data_q       <= m_data_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign s_ready_o      = s_ready_q;
  assign fir_rst_o      = fir_rst_q;
  assign fir_in_valid_o = fir_in_valid_q;
  assign fir_data_in_o  = fir_data_in_q;
  assign m_valid_o      = m_valid_q;
  assign m_last_o       = m_last_q;
  assign m_data_o       = m_data_q;

endmodule
